// File: rtl/fifo_tx_pkg.sv
// Shared types and defaults for the FIFO serial drain engine.
// Holds the frame FSM encoding and the line idle level.
package fifo_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int   DATA_W_DEF     = 4;
    localparam int   BIT_CYCLES_DEF = 4;
    localparam logic IDLE_LEVEL     = 1'b1;

endpackage

// File: rtl/fifo_serial_tx_bit_timer.sv
// Purpose: bit-period counter; 'last' marks the final cycle of each BIT_CYCLES period.
// Latency: restart clears the count on the next edge; 'last' is combinational from the count.
// Backpressure: none, free-running while restart is low.
module bit_timer
    import fifo_tx_pkg::*;
#(
    parameter int BIT_CYCLES = BIT_CYCLES_DEF
) (
    input  logic clk,
    input  logic clr,
    input  logic restart,
    output logic last
);

    localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Wrapping on 'last' restarts the period automatically for back-to-back bits.
    always_ff @(posedge clk) begin
        if (clr || restart || last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign last = (cnt == CNT_MAX);

endmodule

// File: rtl/fifo_serial_tx.sv
// Purpose: pops the FIFO head and sends it as start/LSB-first data/stop on tx.
// Latency: start bit begins 1 clk after IDLE sees en=1 and fifo_empty=0; frame is (DATA_W+2)*BIT_CYCLES.
// Backpressure: en and fifo_empty are only sampled in IDLE; a started frame always completes.
module fifo_serial_tx
    import fifo_tx_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int BIT_CYCLES = BIT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_read,
    output logic              tx,
    output logic              busy,
    output logic [7:0]        frames_sent
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    tx_state_t         state, state_nxt;
    logic [DATA_W-1:0] shift, shift_nxt, shift_sh;
    logic [IDX_W-1:0]  bit_idx, bit_idx_nxt;
    logic              tx_nxt, busy_nxt, read_nxt;
    logic [7:0]        frames_nxt;
    logic              bit_last;

    // Holding the timer in restart while idle makes every timed state start at count 0.
    bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clk     (clk),
        .clr     (clr),
        .restart (state == IDLE),
        .last    (bit_last)
    );

    assign shift_sh = shift >> 1;

    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift;
        bit_idx_nxt = '0;
        tx_nxt      = IDLE_LEVEL;
        busy_nxt    = 1'b1;
        read_nxt    = 1'b0;
        frames_nxt  = frames_sent;
        unique case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                if (en && !fifo_empty) begin
                    state_nxt = START;
                    shift_nxt = fifo_dout;
                    read_nxt  = 1'b1;
                    tx_nxt    = ~IDLE_LEVEL;
                    busy_nxt  = 1'b1;
                end
            end
            START: begin
                tx_nxt = ~IDLE_LEVEL;
                if (bit_last) begin
                    state_nxt = DATA;
                    tx_nxt    = shift[0];
                end
            end
            DATA: begin
                tx_nxt      = shift[0];
                bit_idx_nxt = bit_idx;
                if (bit_last) begin
                    if (bit_idx == IDX_LAST) begin
                        state_nxt   = STOP;
                        tx_nxt      = IDLE_LEVEL;
                        bit_idx_nxt = '0;
                    end else begin
                        shift_nxt   = shift_sh;
                        tx_nxt      = shift_sh[0];
                        bit_idx_nxt = bit_idx + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (bit_last) begin
                    state_nxt  = IDLE;
                    busy_nxt   = 1'b0;
                    frames_nxt = frames_sent + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // A reset mid-frame drops the already-popped word; it is never re-read.
    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= IDLE;
            shift       <= '0;
            bit_idx     <= '0;
            tx          <= IDLE_LEVEL;
            busy        <= 1'b0;
            fifo_read   <= 1'b0;
            frames_sent <= 8'd0;
        end else begin
            state       <= state_nxt;
            shift       <= shift_nxt;
            bit_idx     <= bit_idx_nxt;
            tx          <= tx_nxt;
            busy        <= busy_nxt;
            fifo_read   <= read_nxt;
            frames_sent <= frames_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: channel 0 uses defaults, channel 1 uses BIT_CYCLES=1.
// A frame-level model predicts tx/busy/fifo_read/frames_sent for every cycle.
module tb_fifo_serial_tx;

    localparam int W = 4;

    typedef struct packed {
        logic tx;
        logic busy;
        logic rd;
        logic last;
    } ent_t;

    localparam ent_t IDLE_E = '{tx: 1'b1, busy: 1'b0, rd: 1'b0, last: 1'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        clr, en, fifo_empty, fifo_read, tx, busy;
    logic [1:0][W-1:0] fifo_dout;
    logic [1:0][7:0]   fs;

    fifo_serial_tx #(.DATA_W(W), .BIT_CYCLES(4)) u_dut (
        .clk(clk), .clr(clr[0]), .en(en[0]), .fifo_dout(fifo_dout[0]),
        .fifo_empty(fifo_empty[0]), .fifo_read(fifo_read[0]), .tx(tx[0]),
        .busy(busy[0]), .frames_sent(fs[0])
    );

    fifo_serial_tx #(.DATA_W(W), .BIT_CYCLES(1)) u_dut1 (
        .clk(clk), .clr(clr[1]), .en(en[1]), .fifo_dout(fifo_dout[1]),
        .fifo_empty(fifo_empty[1]), .fifo_read(fifo_read[1]), .tx(tx[1]),
        .busy(busy[1]), .frames_sent(fs[1])
    );

    ent_t       pend[2][$];
    ent_t       cur[2];
    logic [7:0] fexp[2];
    logic [W-1:0] fq[2][$];
    int         rd_cnt[2];
    logic [63:0] hist0;
    int         n_chk = 0;
    int         n_fail = 0;
    bit         check_on = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int bc(input int ch);
        return (ch == 0) ? 4 : 1;
    endfunction

    // Frame model: whole frame waveform laid out from the bit number of each cycle.
    initial begin
        for (int ch = 0; ch < 2; ch++) begin
            cur[ch]  = IDLE_E;
            fexp[ch] = 8'd0;
        end
        forever begin
            @(posedge clk);
            for (int ch = 0; ch < 2; ch++) begin
                if (clr[ch] === 1'b1) begin
                    pend[ch].delete();
                    cur[ch]  = IDLE_E;
                    fexp[ch] = 8'd0;
                end else begin
                    if (cur[ch].last) fexp[ch] = fexp[ch] + 8'd1;
                    if (pend[ch].size() > 0) begin
                        cur[ch] = pend[ch].pop_front();
                    end else if (!cur[ch].busy && en[ch] && !fifo_empty[ch]) begin
                        int fl;
                        fl = (W + 2) * bc(ch);
                        for (int j = 0; j < fl; j++) begin
                            int   b;
                            ent_t e;
                            b      = j / bc(ch);
                            e.tx   = (b == 0) ? 1'b0 : (b <= W) ? fifo_dout[ch][b-1] : 1'b1;
                            e.busy = 1'b1;
                            e.rd   = (j == 0);
                            e.last = (j == fl - 1);
                            pend[ch].push_back(e);
                        end
                        cur[ch] = pend[ch].pop_front();
                    end else begin
                        cur[ch] = IDLE_E;
                    end
                end
            end
        end
    end

    // Per-cycle compare plus the FIFO read side reacting to the DUT pop strobe.
    initial begin
        fifo_empty = '1;
        fifo_dout  = '0;
        rd_cnt[0]  = 0;
        rd_cnt[1]  = 0;
        hist0      = '0;
        forever begin
            @(negedge clk);
            for (int ch = 0; ch < 2; ch++) begin
                if (check_on) begin
                    chk($sformatf("tx%0d", ch), int'(tx[ch]), int'(cur[ch].tx));
                    chk($sformatf("busy%0d", ch), int'(busy[ch]), int'(cur[ch].busy));
                    chk($sformatf("fifo_read%0d", ch), int'(fifo_read[ch]), int'(cur[ch].rd));
                    chk($sformatf("frames_sent%0d", ch), int'(fs[ch]), int'(fexp[ch]));
                end
                if (fifo_read[ch] === 1'b1) begin
                    if (fq[ch].size() > 0) void'(fq[ch].pop_front());
                    rd_cnt[ch]++;
                end
                fifo_empty[ch] = (fq[ch].size() == 0);
                fifo_dout[ch]  = (fq[ch].size() == 0) ? '0 : fq[ch][0];
            end
            hist0 = {hist0[62:0], tx[0]};
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int r0, t;
        logic [23:0] frame;
        clr = 2'b11;
        en  = 2'b00;
        tick(2);
        clr = 2'b00;
        check_on = 1'b1;

        // Reset then idle
        tick(10);
        chk("idle_tx", int'(tx[0]), 1);
        chk("idle_frames", int'(fs[0]), 0);

        // Single word 4'b1010
        en[0] = 1'b1;
        r0 = rd_cnt[0];
        fq[0].push_back(4'b1010);
        tick(26);
        frame = hist0[24:1];
        chk("single_wave", int'(frame), int'(24'h00F0FF));
        chk("single_reads", rd_cnt[0] - r0, 1);
        chk("single_frames", int'(fs[0]), 1);

        // Back-to-back from a fresh reset
        clr[0] = 1'b1;
        tick(1);
        clr[0] = 1'b0;
        r0 = rd_cnt[0];
        fq[0].push_back(4'hF);
        fq[0].push_back(4'h3);
        fq[0].push_back(4'h0);
        fq[0].push_back(4'h9);
        tick(102);
        chk("b2b_reads", rd_cnt[0] - r0, 4);
        chk("b2b_frames", int'(fs[0]), 4);

        // Enable gating
        en[0] = 1'b0;
        r0 = rd_cnt[0];
        fq[0].push_back(4'h6);
        tick(20);
        chk("gate_reads", rd_cnt[0] - r0, 0);
        chk("gate_tx", int'(tx[0]), 1);
        en[0] = 1'b1;
        tick(1);
        chk("gate_start_tx", int'(tx[0]), 0);
        chk("gate_start_rd", int'(fifo_read[0]), 1);
        tick(5);
        en[0] = 1'b0;
        tick(30);
        chk("gate_frames", int'(fs[0]), 5);
        chk("gate_reads_done", rd_cnt[0] - r0, 1);

        // Reset mid-frame on cycle 10 of a 4'h5 frame
        en[0] = 1'b1;
        r0 = rd_cnt[0];
        fq[0].push_back(4'h5);
        tick(9);
        clr[0] = 1'b1;
        tick(1);
        clr[0] = 1'b0;
        chk("mid_clr_tx", int'(tx[0]), 1);
        chk("mid_clr_busy", int'(busy[0]), 0);
        chk("mid_clr_frames", int'(fs[0]), 0);
        tick(5);
        chk("mid_clr_reads", rd_cnt[0] - r0, 1);

        // Randomised traffic, enable and occasional reset on channel 0
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(3) == 0 && fq[0].size() < 8) fq[0].push_back(W'($urandom));
            en[0]  = ($urandom_range(7) != 0);
            clr[0] = ($urandom_range(399) == 0);
            tick(1);
        end
        clr[0] = 1'b0;
        en[0]  = 1'b1;
        t = 0;
        while ((fq[0].size() != 0 || busy[0]) && t < 500) begin
            tick(1);
            t++;
        end
        chk("rand_drained", int'(t < 500), 1);

        // Counter wrap with BIT_CYCLES=1
        en[1] = 1'b1;
        r0 = rd_cnt[1];
        for (int i = 0; i < 256; i++) fq[1].push_back(W'($urandom));
        tick(2);
        t = 0;
        while ((fq[1].size() != 0 || busy[1]) && t < 3000) begin
            tick(1);
            t++;
        end
        chk("wrap_drained", int'(t < 3000), 1);
        tick(2);
        chk("wrap_reads", rd_cnt[1] - r0, 256);
        chk("wrap_frames", int'(fs[1]), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_serial_tx.md
# fifo_serial_tx

Read-side drain engine for the team's 4-bit fall-through FIFO. Whenever the FIFO is non-empty and the block is enabled, it pops one word and transmits it on a single serial line as a framed character: start bit, data LSB-first, stop bit. It sits between the FIFO's `dout`/`empty`/`read` port and an off-block serial link. It is the consumer counterpart to the FIFO's write side.

## Interface
Parameters:
- DATA_W, default 4: word width; must match the FIFO width.
- BIT_CYCLES, default 4: clock cycles per serial bit; legal values are 1 or more.

Ports:
- clk  in  1  single system clock; all state changes on its rising edge.
- clr  in  1  synchronous, active-high reset.
- en  in  1  permits starting a new frame; does not affect a frame already in progress.
- fifo_dout  in  DATA_W  FIFO head word; valid whenever fifo_empty=0.
- fifo_empty  in  1  FIFO empty flag.
- fifo_read  out  1  pop strobe to the FIFO; exactly one clk cycle wide per frame.
- tx  out  1  serial line; idles high.
- busy  out  1  high from the first start-bit cycle through the last stop-bit cycle.
- frames_sent  out  8  count of completed frames; wraps from 255 to 0.

## Operation
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - On a clk edge with en=1 and fifo_empty=0: capture fifo_dout into the shift register, set fifo_read<=1, tx<=0, busy<=1, and go to START.
  - Otherwise stay in IDLE with tx=1 and fifo_read=0.
- START: hold tx=0 for BIT_CYCLES cycles, then go to DATA with tx=shift[0].
- DATA:
  - Each bit is held for BIT_CYCLES cycles, then the shift register moves right by one.
  - After DATA_W bits, go to STOP with tx=1.
- STOP:
  - Hold tx=1 for BIT_CYCLES cycles.
  - On the final cycle, frames_sent increments (modulo 256), busy<=0, and the state returns to IDLE.
- fifo_read is registered. It is high only during the first START cycle and is never reasserted within a frame.
- en or fifo_empty changing mid-frame has no effect. Both are sampled only in IDLE.
- Back-to-back traffic: after STOP, exactly one IDLE cycle with tx=1 occurs before the next START.
- Bit-cycle counter width is clog2(BIT_CYCLES), minimum 1. Bit index width is clog2(DATA_W), minimum 1. Counters reset to 0 on every state entry.

## Timing
- Reset values (clr=1 at an edge): state=IDLE, tx=1, busy=0, fifo_read=0, frames_sent=0, shift register=0, counters=0.
- clr takes priority over all other inputs.
- Reset mid-frame:
  - tx returns high on the next cycle.
  - The word already popped is discarded and not re-popped.
  - frames_sent is cleared.
- Frame length is (DATA_W+2)*BIT_CYCLES cycles. With defaults, 24 cycles.
- Latency from the edge where IDLE samples fifo_empty=0 to the first start-bit cycle is 1 clk.
- Sustained throughput is one word per (DATA_W+2)*BIT_CYCLES+1 cycles.
- BIT_CYCLES=1: each bit lasts exactly one cycle, and the frame is DATA_W+2 cycles.
- The FIFO must settle its new head within the frame duration. The block never reads fifo_dout outside IDLE.

## Structure
- Shared package `fifo_tx_pkg`:
  - state enum (IDLE, START, DATA, STOP)
  - DATA_W_DEF=4, BIT_CYCLES_DEF=4
  - IDLE_LEVEL=1'b1
- One sub-module, `bit_timer`: a counter of BIT_CYCLES width.
  - Inputs: clk, clr, restart.
  - Output: a `last` pulse on the final cycle of each bit period.
  - Used by the FSM for all three timed states.
- Top-level contents: FSM, shift register, bit index, frames_sent counter.

## Test plan
- Reset then idle: clr=1 for 2 cycles, then 10 cycles with fifo_empty=1 -> tx=1, busy=0, fifo_read=0, frames_sent=0 throughout.
- Single word: fifo_dout=4'b1010, fifo_empty falls for one pop (defaults) -> fifo_read high for 1 cycle; tx sequence of 4 cycles each is 0 / 0,1,0,1 / 1 (24 cycles total); frames_sent=1.
- Back-to-back: FIFO holds 4'hF, 4'h3, 4'h0, 4'h9 -> 4 frames; each pair separated by exactly 1 idle-high cycle; 4 fifo_read pulses; frames_sent=4.
- Enable gating: en=0 with fifo_empty=0 for 20 cycles -> no pop, tx=1. Then en=1 -> START begins 1 cycle later. Dropping en mid-frame -> frame completes unchanged.
- Reset mid-frame: clr=1 at cycle 10 of a 4'h5 frame -> tx=1 the next cycle, busy=0, frames_sent=0, no extra fifo_read.
- Counter wrap and BIT_CYCLES=1: 256 frames with BIT_CYCLES=1 -> each frame is 6 cycles and frames_sent wraps 255->0.
